// File: rtl/exp_sig_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// exp_sig_sweep_ctrl
//
// Drives the test inputs (overlay, rate, delay) of the exponential signal
// generator through a programmed delay sweep. For every delay value the
// block first settles with generation disabled, then dwells with the
// latched mode bits applied. Progress is reported so benches can align
// captures to each step.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   start         request a sweep (only honoured while idle)
//   stop          abort a running sweep
//   delay_first   first delay value of the sweep
//   delay_last    largest delay value allowed in the sweep
//   delay_step    delay increment per step (0 -> single step)
//   dwell_cycles  generation-enabled cycles per step (0 treated as 1)
//   mode_overlay  overlay value applied while dwelling
//   mode_rate     rate value applied while dwelling
//   test_overlay  generator overlay input
//   test_rate     generator rate input
//   test_delay    generator delay input
//   busy          high while settling or dwelling
//   step_strobe   one-cycle pulse on the first dwell cycle of each step
//   step_index    0-based index of the current step
//   done          one-cycle pulse on normal completion
//   aborted       one-cycle pulse when stop ends a sweep
// ----------------------------------------------------------------------------
module exp_sig_sweep_ctrl #(
    parameter int SIZE_DELAY    = 8,
    parameter int SIZE_DWELL    = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [SIZE_DELAY-1:0] delay_first,
    input  logic [SIZE_DELAY-1:0] delay_last,
    input  logic [SIZE_DELAY-1:0] delay_step,
    input  logic [SIZE_DWELL-1:0] dwell_cycles,
    input  logic                  mode_overlay,
    input  logic                  mode_rate,
    output logic                  test_overlay,
    output logic                  test_rate,
    output logic [SIZE_DELAY-1:0] test_delay,
    output logic                  busy,
    output logic                  step_strobe,
    output logic [SIZE_DELAY-1:0] step_index,
    output logic                  done,
    output logic                  aborted
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [SET_W-1:0]      SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0]      SET_ONE     = SET_W'(1);
    localparam logic [SIZE_DWELL-1:0] DWELL_ONE   = SIZE_DWELL'(1);
    localparam logic [SIZE_DELAY-1:0] DELAY_ONE   = SIZE_DELAY'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [SET_W-1:0]      settle_cnt_q, settle_cnt_d;
    logic [SIZE_DWELL-1:0] dwell_cnt_q, dwell_cnt_d;

    // Sweep parameters captured at start so later input changes are ignored.
    logic [SIZE_DELAY-1:0] last_q, last_d;
    logic [SIZE_DELAY-1:0] step_q, step_d;
    logic [SIZE_DWELL-1:0] dwell_q, dwell_d;
    logic                  ovl_q, ovl_d;
    logic                  rate_q, rate_d;

    // Registered outputs.
    logic [SIZE_DELAY-1:0] test_delay_q, test_delay_d;
    logic [SIZE_DELAY-1:0] step_index_q, step_index_d;
    logic                  test_overlay_q, test_overlay_d;
    logic                  test_rate_q, test_rate_d;
    logic                  busy_q, busy_d;
    logic                  step_strobe_q, step_strobe_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;

    logic                  abort_evt;
    // One extra bit so an increment past the top of the range is seen as
    // exceeding delay_last instead of wrapping to a small delay.
    logic [SIZE_DELAY:0]   nxt_delay;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            settle_cnt_q   <= '0;
            dwell_cnt_q    <= '0;
            last_q         <= '0;
            step_q         <= '0;
            dwell_q        <= '0;
            ovl_q          <= 1'b0;
            rate_q         <= 1'b0;
            test_delay_q   <= '0;
            step_index_q   <= '0;
            test_overlay_q <= 1'b0;
            test_rate_q    <= 1'b0;
            busy_q         <= 1'b0;
            step_strobe_q  <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            settle_cnt_q   <= settle_cnt_d;
            dwell_cnt_q    <= dwell_cnt_d;
            last_q         <= last_d;
            step_q         <= step_d;
            dwell_q        <= dwell_d;
            ovl_q          <= ovl_d;
            rate_q         <= rate_d;
            test_delay_q   <= test_delay_d;
            step_index_q   <= step_index_d;
            test_overlay_q <= test_overlay_d;
            test_rate_q    <= test_rate_d;
            busy_q         <= busy_d;
            step_strobe_q  <= step_strobe_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        last_d       = last_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        ovl_d        = ovl_q;
        rate_d       = rate_q;
        test_delay_d = test_delay_q;
        step_index_d = step_index_q;
        abort_evt    = 1'b0;
        nxt_delay    = {1'b0, test_delay_q} + {1'b0, step_q};

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_LOAD;
                    test_delay_d = delay_first;
                    step_index_d = '0;
                    last_d       = delay_last;
                    step_d       = delay_step;
                    dwell_d      = dwell_cycles;
                    ovl_d        = mode_overlay;
                    rate_d       = mode_rate;
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    abort_evt = 1'b1;
                end else if (settle_cnt_q == '0) begin
                    state_d = ST_DWELL;
                    // A zero dwell count still gives one dwell cycle.
                    dwell_cnt_d = (dwell_q == '0) ? '0 : (dwell_q - DWELL_ONE);
                end else begin
                    settle_cnt_d = settle_cnt_q - SET_ONE;
                end
            end
            ST_DWELL: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    abort_evt = 1'b1;
                end else if (dwell_cnt_q == '0) begin
                    if ((step_q == '0) || (nxt_delay > {1'b0, last_q})) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                        test_delay_d = nxt_delay[SIZE_DELAY-1:0];
                        step_index_d = step_index_q + DELAY_ONE;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: values the output registers take on the next edge
    // ------------------------------------------------------------------
    always_comb begin
        busy_d         = (state_d == ST_SETTLE) || (state_d == ST_DWELL);
        // DWELL is only ever entered from SETTLE, so this marks its first cycle.
        step_strobe_d  = (state_q == ST_SETTLE) && (state_d == ST_DWELL);
        done_d         = (state_d == ST_DONE);
        aborted_d      = abort_evt;
        test_overlay_d = (state_d == ST_DWELL) && ovl_q;
        test_rate_d    = (state_d == ST_DWELL) && rate_q;
    end

    assign test_overlay = test_overlay_q;
    assign test_rate    = test_rate_q;
    assign test_delay   = test_delay_q;
    assign busy         = busy_q;
    assign step_strobe  = step_strobe_q;
    assign step_index   = step_index_q;
    assign done         = done_q;
    assign aborted      = aborted_q;

endmodule

// File: tb/tb_exp_sig_sweep_ctrl.sv
module tb_exp_sig_sweep_ctrl;

    localparam int SD = 8;
    localparam int SW = 16;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [SD-1:0] delay_first = '0;
    logic [SD-1:0] delay_last = '0;
    logic [SD-1:0] delay_step = '0;
    logic [SW-1:0] dwell_cycles = '0;
    logic          mode_overlay = 1'b0;
    logic          mode_rate = 1'b0;
    logic          test_overlay, test_rate, busy, step_strobe, done, aborted;
    logic [SD-1:0] test_delay, step_index;

    exp_sig_sweep_ctrl #(.SIZE_DELAY(SD), .SIZE_DWELL(SW), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .delay_first(delay_first), .delay_last(delay_last), .delay_step(delay_step),
        .dwell_cycles(dwell_cycles), .mode_overlay(mode_overlay), .mode_rate(mode_rate),
        .test_overlay(test_overlay), .test_rate(test_rate), .test_delay(test_delay),
        .busy(busy), .step_strobe(step_strobe), .step_index(step_index),
        .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          busy;
        logic          strobe;
        logic          done;
        logic          aborted;
        logic          ovl;
        logic          rate;
        logic [SD-1:0] delay;
        logic [SD-1:0] index;
    } obs_t;

    obs_t exp_o = '0;
    obs_t plan[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   strobe_cyc[$];
    int   strobe_dly[$];
    int   done_cyc[$];
    int   abort_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(bit b, bit s, bit d, bit a, bit o, bit r, int dl, int ix);
        obs_t t;
        t.busy = b; t.strobe = s; t.done = d; t.aborted = a; t.ovl = o; t.rate = r;
        t.delay = dl[SD-1:0];
        t.index = ix[SD-1:0];
        return t;
    endfunction

    // Whole-sweep expected trace, one entry per cycle, built from the sweep rules.
    task automatic build_plan(int first, int last, int step, int dwell, bit ovl, bit rt);
        int d   = first;
        int idx = 0;
        int dw  = (dwell == 0) ? 1 : dwell;
        forever begin
            for (int k = 0; k < SC; k++) plan.push_back(mk(1, 0, 0, 0, 0, 0, d, idx));
            for (int k = 0; k < dw; k++) plan.push_back(mk(1, k == 0, 0, 0, ovl, rt, d, idx));
            if (step == 0 || d + step > last) break;
            d   = d + step;
            idx = idx + 1;
        end
        plan.push_back(mk(0, 0, 1, 0, 0, 0, d, idx));
    endtask

    // Reference model: advances once per clock edge, cleared by reset.
    obs_t cur;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            plan.delete();
            exp_o = '0;
        end else begin
            cur = exp_o;
            if (cur.busy && stop) begin
                plan.delete();
                exp_o = mk(0, 0, 0, 1, 0, 0, int'(cur.delay), int'(cur.index));
            end else if (plan.size() > 0) begin
                exp_o = plan.pop_front();
            end else if (!cur.busy && !cur.done && start && !stop) begin
                build_plan(int'(delay_first), int'(delay_last), int'(delay_step),
                           int'(dwell_cycles), mode_overlay, mode_rate);
                exp_o = plan.pop_front();
            end else begin
                exp_o = mk(0, 0, 0, 0, 0, 0, int'(cur.delay), int'(cur.index));
            end
        end
    end

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Advance to the next falling edge, compare every output with the model, log events.
    task automatic tick();
        obs_t act;
        @(negedge clk);
        act = {busy, step_strobe, done, aborted, test_overlay, test_rate, test_delay, step_index};
        checks++;
        if (act !== exp_o) begin
            failures++;
            $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act, exp_o);
        end
        if (step_strobe === 1'b1) begin
            strobe_cyc.push_back(cyc);
            strobe_dly.push_back(int'(test_delay));
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
        if (aborted === 1'b1) abort_cyc.push_back(cyc);
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        strobe_cyc.delete(); strobe_dly.delete(); done_cyc.delete(); abort_cyc.delete();
    endtask

    task automatic set_cfg(int f, int l, int s, int dw, bit o, bit r);
        delay_first = f[SD-1:0]; delay_last = l[SD-1:0]; delay_step = s[SD-1:0];
        dwell_cycles = dw[SW-1:0]; mode_overlay = o; mode_rate = r;
    endtask

    // Pulse start for one cycle; returns the cycle it was sampled in.
    task automatic pulse_start(output int t);
        t = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int t0;
    int guard;

    initial begin
        // Reset state
        run(3);
        chk("reset_busy", int'(busy), 0);
        chk("reset_delay", int'(test_delay), 0);
        chk("reset_index", int'(step_index), 0);
        reset = 1'b1;
        run(2);

        // start and stop together while idle are ignored
        set_cfg(2, 6, 2, 5, 1, 0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        run(2);
        chk("start_stop_idle_busy", int'(busy), 0);

        // Basic sweep with a start pulse while busy and input changes after start
        clear_logs();
        pulse_start(t0);
        $display("sweep basic: first=2 last=6 step=2 dwell=5 start=%0d", t0);
        set_cfg(0, 200, 1, 1, 0, 1);
        for (int i = 0; i < 38; i++) begin
            start = (i == 8);
            tick();
        end
        start = 1'b0;
        chk("basic_strobe_count", strobe_cyc.size(), 3);
        if (strobe_cyc.size() == 3) begin
            chk("basic_strobe0", strobe_cyc[0] - t0, 5);
            chk("basic_strobe1", strobe_cyc[1] - t0, 14);
            chk("basic_strobe2", strobe_cyc[2] - t0, 23);
            chk("basic_delay0", strobe_dly[0], 2);
            chk("basic_delay1", strobe_dly[1], 4);
            chk("basic_delay2", strobe_dly[2], 6);
        end
        chk("basic_done_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk("basic_done_cycle", done_cyc[0] - t0, 28);

        // Overflow guard near the top of the delay range
        set_cfg(250, 255, 4, 2, 0, 0);
        clear_logs();
        pulse_start(t0);
        $display("sweep overflow: first=250 last=255 step=4 dwell=2 start=%0d", t0);
        run(25);
        chk("ovf_strobe_count", strobe_cyc.size(), 2);
        if (strobe_cyc.size() == 2) begin
            chk("ovf_delay0", strobe_dly[0], 250);
            chk("ovf_delay1", strobe_dly[1], 254);
        end
        chk("ovf_done_count", done_cyc.size(), 1);

        // Stop in the second dwell cycle, then a fresh start
        set_cfg(10, 40, 10, 4, 1, 1);
        clear_logs();
        pulse_start(t0);
        $display("sweep stop: first=10 last=40 step=10 dwell=4 start=%0d", t0);
        guard = 0;
        while (cyc < t0 + 6 && guard < 20) begin tick(); guard++; end
        chk("stop_in_dwell_ovl", int'(test_overlay), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_aborted", int'(aborted), 1);
        chk("stop_ovl_rate", int'({test_overlay, test_rate}), 0);
        run(6);
        chk("stop_no_done", done_cyc.size(), 0);
        clear_logs();
        pulse_start(t0);
        run(8);
        chk("restart_strobe_count", strobe_cyc.size(), 1);
        if (strobe_cyc.size() == 1) chk("restart_strobe_cycle", strobe_cyc[0] - t0, 5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run(2);

        // Asynchronous reset in the middle of a dwell
        set_cfg(20, 100, 1, 8, 1, 0);
        pulse_start(t0);
        $display("sweep reset: first=20 last=100 step=1 dwell=8 start=%0d", t0);
        guard = 0;
        while (cyc < t0 + 7 && guard < 20) begin tick(); guard++; end
        chk("reset_pre_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_delay", int'(test_delay), 0);
        chk("async_ovl", int'(test_overlay), 0);
        tick();
        reset = 1'b1;
        run(4);
        chk("after_reset_busy", int'(busy), 0);

        // Degenerate: zero step and zero dwell
        set_cfg(7, 50, 0, 0, 1, 1);
        clear_logs();
        pulse_start(t0);
        $display("sweep degenerate: first=7 last=50 step=0 dwell=0 start=%0d", t0);
        run(10);
        chk("degen_strobe_count", strobe_cyc.size(), 1);
        chk("degen_done_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk("degen_done_cycle", done_cyc[0] - t0, 6);

        // first > last gives exactly one step
        set_cfg(9, 3, 1, 2, 0, 1);
        clear_logs();
        pulse_start(t0);
        $display("sweep reversed: first=9 last=3 step=1 dwell=2 start=%0d", t0);
        run(10);
        chk("rev_strobe_count", strobe_cyc.size(), 1);
        if (strobe_dly.size() == 1) chk("rev_delay", strobe_dly[0], 9);
        if (done_cyc.size() == 1) chk("rev_done_cycle", done_cyc[0] - t0, 7);
        else chk("rev_done_count", done_cyc.size(), 1);

        // Randomized sweeps with stray start/stop and input churn
        for (int n = 0; n < 40; n++) begin
            int f, l, s, dw;
            f  = $urandom_range(0, 255);
            l  = $urandom_range(0, 255);
            s  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(4, 80);
            dw = $urandom_range(0, 5);
            set_cfg(f, l, s, dw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            stop = ($urandom_range(0, 7) == 0);
            $display("sweep rand %0d: first=%0d last=%0d step=%0d dwell=%0d stop_at_start=%0b",
                     n, f, l, s, dw, stop);
            pulse_start(t0);
            stop = 1'b0;
            guard = 0;
            while ((exp_o.busy || exp_o.done) && guard < 2000) begin
                stop  = ($urandom_range(0, 149) == 0);
                start = ($urandom_range(0, 15) == 0);
                delay_first = SD'($urandom_range(0, 255));
                mode_overlay = 1'($urandom_range(0, 1));
                tick();
                guard++;
            end
            start = 1'b0; stop = 1'b0;
            if (guard >= 2000) chk("rand_sweep_timeout", guard, 0);
            run(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
